// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans the enabled ADC channels once per sample period, runs each conversion handshake, emits timestamped samples.
// Latency: period tick -> adc_conversion_start 1 cycle; adc_drdy -> sample_valid 1 cycle; channel end -> next start 2 cycles.
// Backpressure: fifo_full never stalls the scan; a sample presented while the FIFO is full is dropped and counted.
module adc_scan_sequencer #(
  parameter int NUM_CHANNELS    = 16,
  parameter int CHANNEL_WIDTH   = $clog2(NUM_CHANNELS),
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int DATA_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CHANNELS-1:0]    channel_mask,
  input  logic [15:0]                sample_period,
  input  logic                       adc_drdy,
  input  logic [DATA_WIDTH-1:0]      adc_data,
  input  logic                       fifo_full,
  output logic                       adc_conversion_start,
  output logic [CHANNEL_WIDTH-1:0]   adc_channel,
  output logic                       adc_conversion_done,
  output logic                       sample_valid,
  output logic [CHANNEL_WIDTH-1:0]   sample_channel,
  output logic [DATA_WIDTH-1:0]      sample_data,
  output logic [TIMESTAMP_WIDTH-1:0] sample_timestamp,
  output logic                       fifo_wr_en,
  output logic                       scan_done,
  output logic                       adc_timeout,
  output logic                       busy,
  output logic [15:0]                drop_count,
  output logic [15:0]                timeout_count,
  output logic [15:0]                overrun_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    CONVERT,
    WRITE,
    NEXT
  } state_t;

  // Timeout counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_q;
  logic [15:0]                period_q;
  logic [15:0]                period_load;
  logic [TO_W-1:0]            tcnt_q;
  logic [NUM_CHANNELS-1:0]    mask_q;
  logic [CHANNEL_WIDTH-1:0]   chan_q, chan_d;
  logic                       latch_mask;
  logic                       tick;
  logic                       busy_s;
  logic                       timeout_hit;
  logic                       scan_done_s;
  logic [CHANNEL_WIDTH-1:0]   samp_chan_q;
  logic [DATA_WIDTH-1:0]      samp_data_q;
  logic [TIMESTAMP_WIDTH-1:0] samp_ts_q;
  logic [15:0]                drop_q, to_q, ovr_q;
  logic [CHANNEL_WIDTH:0]     first_sel, next_sel;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [CHANNEL_WIDTH:0] find_set(input logic [NUM_CHANNELS-1:0] m, input int lo);
    logic [CHANNEL_WIDTH:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, CHANNEL_WIDTH'(i)};
    end
    return r;
  endfunction

  // A scan starts from the live mask; later channels come from the copy latched at scan start.
  assign first_sel = find_set(channel_mask, 0);
  assign next_sel  = find_set(mask_q, int'(chan_q) + 1);

  // A zero period behaves like a period of one (tick every cycle).
  assign period_load = (sample_period == 16'd0) ? 16'd0 : (sample_period - 16'd1);
  assign tick        = enable && (state_q != IDLE) && (period_q == 16'd0);
  assign busy_s      = (state_q != IDLE) && (state_q != WAIT_TICK);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, channel selection and event pulses.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    latch_mask  = 1'b0;
    timeout_hit = 1'b0;
    scan_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick && (|channel_mask)) begin
          latch_mask = 1'b1;
          chan_d     = first_sel[CHANNEL_WIDTH-1:0];
          state_d    = START;
        end
      end
      START: begin
        state_d = CONVERT;
      end
      CONVERT: begin
        // Data ready takes priority over a timeout landing on the same cycle.
        if (adc_drdy) begin
          state_d = WRITE;
        end else if (tcnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = NEXT;
        end
      end
      WRITE: begin
        state_d = NEXT;
      end
      NEXT: begin
        // Losing enable mid-scan abandons the rest of the scan silently.
        if (!enable) begin
          state_d = IDLE;
        end else if (next_sel[CHANNEL_WIDTH]) begin
          chan_d  = next_sel[CHANNEL_WIDTH-1:0];
          state_d = START;
        end else begin
          scan_done_s = 1'b1;
          state_d     = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TIMESTAMP_WIDTH'(1);
  end

  // Period counter: loaded on leaving IDLE, reloaded on every tick, frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= 16'd0;
    end else if (enable) begin
      if (state_q == IDLE || period_q == 16'd0) period_q <= period_load;
      else                                      period_q <= period_q - 16'd1;
    end
  end

  // Conversion timeout counter, cleared when a conversion is started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tcnt_q <= '0;
    else if (state_q == START)    tcnt_q <= '0;
    else if (state_q == CONVERT)  tcnt_q <= tcnt_q + TO_W'(1);
  end

  // Selected channel and the scan's latched mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
      mask_q <= '0;
    end else begin
      chan_q <= chan_d;
      if (latch_mask) mask_q <= channel_mask;
    end
  end

  // Sample capture on the data-ready cycle of an active conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_chan_q <= '0;
      samp_data_q <= '0;
      samp_ts_q   <= '0;
    end else if (state_q == CONVERT && adc_drdy) begin
      samp_chan_q <= chan_q;
      samp_data_q <= adc_data;
      samp_ts_q   <= ts_q;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'd0;
      to_q   <= 16'd0;
      ovr_q  <= 16'd0;
    end else begin
      if (state_q == WRITE && fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (timeout_hit && to_q != 16'hFFFF)                     to_q   <= to_q + 16'd1;
      if (tick && busy_s && ovr_q != 16'hFFFF)                 ovr_q  <= ovr_q + 16'd1;
    end
  end

  assign adc_conversion_start = (state_q == START);
  assign adc_channel          = chan_q;
  assign adc_conversion_done  = (state_q == WRITE);
  assign sample_valid         = (state_q == WRITE);
  assign sample_channel       = samp_chan_q;
  assign sample_data          = samp_data_q;
  assign sample_timestamp     = samp_ts_q;
  assign fifo_wr_en           = sample_valid & ~fifo_full;
  assign scan_done            = scan_done_s;
  assign adc_timeout          = timeout_hit;
  assign busy                 = busy_s;
  assign drop_count           = drop_q;
  assign timeout_count        = to_q;
  assign overrun_count        = ovr_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed scenarios against adc_scan_sequencer with a short timeout.
// Latency: expectations are hand-computed cycle offsets from the observed conversion start.
// Backpressure: fifo_full is driven directly by the scenarios.
module tb_adc_scan_sequencer;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] channel_mask = 16'h0;
  logic [15:0] sample_period = 16'h0;
  logic        adc_drdy = 1'b0;
  logic [15:0] adc_data = 16'h0;
  logic        fifo_full = 1'b0;

  logic        adc_conversion_start;
  logic [3:0]  adc_channel;
  logic        adc_conversion_done;
  logic        sample_valid;
  logic [3:0]  sample_channel;
  logic [15:0] sample_data;
  logic [31:0] sample_timestamp;
  logic        fifo_wr_en;
  logic        scan_done;
  logic        adc_timeout;
  logic        busy;
  logic [15:0] drop_count;
  logic [15:0] timeout_count;
  logic [15:0] overrun_count;

  int errors = 0;
  int checks = 0;

  adc_scan_sequencer #(
    .NUM_CHANNELS(16), .TIMESTAMP_WIDTH(32), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .channel_mask(channel_mask),
    .sample_period(sample_period), .adc_drdy(adc_drdy), .adc_data(adc_data),
    .fifo_full(fifo_full), .adc_conversion_start(adc_conversion_start),
    .adc_channel(adc_channel), .adc_conversion_done(adc_conversion_done),
    .sample_valid(sample_valid), .sample_channel(sample_channel),
    .sample_data(sample_data), .sample_timestamp(sample_timestamp),
    .fifo_wr_en(fifo_wr_en), .scan_done(scan_done), .adc_timeout(adc_timeout),
    .busy(busy), .drop_count(drop_count), .timeout_count(timeout_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  logic [110:0] all_out;
  assign all_out = {adc_conversion_start, adc_channel, adc_conversion_done, sample_valid,
                    sample_channel, sample_data, sample_timestamp, fifo_wr_en, scan_done,
                    adc_timeout, busy, drop_count, timeout_count, overrun_count};

  // Reference cycle count: zero in reset, +1 per clock afterwards.
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  // Event tallies sampled mid-cycle.
  int n_start = 0, n_samp = 0, n_wr = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_conversion_start === 1'b1) n_start++;
      if (sample_valid === 1'b1)         n_samp++;
      if (fifo_wr_en === 1'b1)           n_wr++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; adc_drdy = 1'b0; fifo_full = 1'b0;
    channel_mask = 16'h0; sample_period = 16'h0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_start(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      if (adc_conversion_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Called in the START cycle; leaves the bench in the cycle after drdy.
  task automatic respond(input int lat, input logic [15:0] d);
    repeat (lat) step();
    adc_drdy = 1'b1;
    adc_data = d;
    step();
    adc_drdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_in: outputs=%h required 0", all_out); end
    rst_n = 1'b1;
    repeat (5) step();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle: outputs=%h required 0", all_out); end
  endtask

  task automatic test_single();
    bit ok;
    logic [31:0] s, prev;
    do_reset();
    channel_mask = 16'h0001; sample_period = 16'd100; enable = 1'b1;
    wait_start(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_first_start: start=0 required 1"); end
    prev = 32'd0;
    for (int k = 0; k < 3; k++) begin
      s = tb_cyc;
      checks++;
      if (adc_channel !== 4'd0) begin errors++; $display("FAIL single_chan: got %0d required 0", adc_channel); end
      if (k > 0) begin
        checks++;
        if (s - prev !== 32'd100) begin errors++; $display("FAIL single_period: got %0d required 100", s - prev); end
      end
      prev = s;
      respond(50, 16'h1230 + 16'(k));
      checks++;
      if ({sample_valid, adc_conversion_done} !== 2'b11) begin
        errors++; $display("FAIL single_valid_done: got %b required 11", {sample_valid, adc_conversion_done});
      end
      checks++;
      if (sample_timestamp !== s + 32'd50) begin
        errors++; $display("FAIL single_ts: got %0d required %0d", sample_timestamp, s + 32'd50);
      end
      checks++;
      if (sample_data !== 16'h1230 + 16'(k) || sample_channel !== 4'd0 || fifo_wr_en !== 1'b1) begin
        errors++; $display("FAIL single_sample: data=%h ch=%0d wr=%b required %h 0 1",
                           sample_data, sample_channel, fifo_wr_en, 16'h1230 + 16'(k));
      end
      step();
      checks++;
      if (scan_done !== 1'b1) begin errors++; $display("FAIL single_scan_done: got %b required 1", scan_done); end
      if (k < 2) begin
        wait_start(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_next_start: start=0 required 1"); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_multi();
    bit ok;
    int ns, nsm;
    logic [3:0] exp_ch [4];
    exp_ch[0] = 4'd0; exp_ch[1] = 4'd2; exp_ch[2] = 4'd13; exp_ch[3] = 4'd15;
    do_reset();
    channel_mask = 16'hA005; sample_period = 16'd1000; enable = 1'b1;
    ns = n_start; nsm = n_samp;
    wait_start(1100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_first_start: start=0 required 1"); end
    channel_mask = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (adc_channel !== exp_ch[i]) begin errors++; $display("FAIL multi_order: got %0d required %0d", adc_channel, exp_ch[i]); end
      respond(5, 16'hB000 | 16'(i));
      checks++;
      if (sample_valid !== 1'b1 || sample_channel !== exp_ch[i] || sample_data !== (16'hB000 | 16'(i))) begin
        errors++; $display("FAIL multi_sample: vld=%b ch=%0d data=%h required 1 %0d %h",
                           sample_valid, sample_channel, sample_data, exp_ch[i], 16'hB000 | 16'(i));
      end
      step();
      if (i < 3) begin
        step();
        checks++;
        if (adc_conversion_start !== 1'b1) begin errors++; $display("FAIL multi_next_latency: start=%b required 1", adc_conversion_start); end
      end else begin
        checks++;
        if (scan_done !== 1'b1) begin errors++; $display("FAIL multi_scan_done: got %b required 1", scan_done); end
      end
    end
    repeat (30) step();
    checks++;
    if (n_samp - nsm !== 4 || n_start - ns !== 4 || busy !== 1'b0) begin
      errors++; $display("FAIL multi_counts: samples=%0d starts=%0d busy=%b required 4 4 0", n_samp - nsm, n_start - ns, busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok, found;
    logic [31:0] s, t;
    int nsm;
    do_reset();
    channel_mask = 16'h0020; sample_period = 16'd10; enable = 1'b1;
    wait_start(50, ok);
    s = tb_cyc; nsm = n_samp;
    checks++;
    if (!ok || adc_channel !== 4'd5) begin errors++; $display("FAIL to_start: ok=%b ch=%0d required 1 5", ok, adc_channel); end
    found = 1'b0; t = 32'd0;
    for (int i = 0; i < TO + 20 && !found; i++) begin
      step();
      if (adc_timeout === 1'b1) begin found = 1'b1; t = tb_cyc; end
    end
    checks++;
    if (!found || t - s !== 32'(TO)) begin errors++; $display("FAIL to_pulse: found=%b delay=%0d required 1 %0d", found, t - s, TO); end
    step();
    checks++;
    if (scan_done !== 1'b1 || timeout_count !== 16'd1) begin
      errors++; $display("FAIL to_done: scan_done=%b timeout_count=%0d required 1 1", scan_done, timeout_count);
    end
    checks++;
    if (n_samp - nsm !== 0) begin errors++; $display("FAIL to_no_sample: samples=%0d required 0", n_samp - nsm); end
  endtask

  // Runs straight after test_timeout: drdy lands on the timeout cycle.
  task automatic test_drdy_timeout_race();
    bit ok;
    wait_start(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL race_start: start=0 required 1"); end
    respond(TO, 16'h5A5A);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h5A5A || sample_channel !== 4'd5) begin
      errors++; $display("FAIL race_sample: vld=%b data=%h ch=%0d required 1 5a5a 5", sample_valid, sample_data, sample_channel);
    end
    step();
    checks++;
    if (timeout_count !== 16'd1 || scan_done !== 1'b1) begin
      errors++; $display("FAIL race_count: timeout_count=%0d scan_done=%b required 1 1", timeout_count, scan_done);
    end
    enable = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit ok;
    int nw;
    do_reset();
    channel_mask = 16'h0007; sample_period = 16'd500; fifo_full = 1'b1; enable = 1'b1;
    nw = n_wr;
    wait_start(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ff_start: start=0 required 1"); end
    for (int i = 0; i < 3; i++) begin
      respond(3, 16'h0F00 + 16'(i));
      checks++;
      if ({sample_valid, fifo_wr_en} !== 2'b10) begin
        errors++; $display("FAIL ff_strobe: vld,wr=%b required 10", {sample_valid, fifo_wr_en});
      end
      step();
      if (i < 2) step();
    end
    step();
    checks++;
    if (drop_count !== 16'd3 || n_wr - nw !== 0) begin
      errors++; $display("FAIL ff_drops: drop_count=%0d writes=%0d required 3 0", drop_count, n_wr - nw);
    end
    fifo_full = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    int ns, bad;
    logic [31:0] s;
    do_reset();
    channel_mask = 16'hFFFF; sample_period = 16'd10; enable = 1'b1;
    ns = n_start;
    wait_start(50, ok);
    s = tb_cyc;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (adc_channel !== 4'(i)) bad++;
      respond(20, 16'(i));
      step();
      if (i < 15) begin
        step();
        if (adc_conversion_start !== 1'b1) bad++;
      end
    end
    checks++;
    if (!ok || bad !== 0) begin errors++; $display("FAIL ovr_sequence: ok=%b bad=%0d required 1 0", ok, bad); end
    checks++;
    if (scan_done !== 1'b1 || tb_cyc - s !== 32'd367) begin
      errors++; $display("FAIL ovr_scan_len: scan_done=%b len=%0d required 1 367", scan_done, tb_cyc - s);
    end
    checks++;
    if (overrun_count !== 16'd36) begin errors++; $display("FAIL ovr_count: got %0d required 36", overrun_count); end
    checks++;
    if (n_start - ns !== 16) begin errors++; $display("FAIL ovr_starts: got %0d required 16", n_start - ns); end
    enable = 1'b0;
  endtask

  task automatic test_enable_mid();
    bit ok;
    int ns;
    do_reset();
    channel_mask = 16'h001A; sample_period = 16'd200; enable = 1'b1;
    wait_start(300, ok);
    checks++;
    if (!ok || adc_channel !== 4'd1) begin errors++; $display("FAIL en_first: ok=%b ch=%0d required 1 1", ok, adc_channel); end
    respond(4, 16'h0001);
    step();
    step();
    checks++;
    if (adc_conversion_start !== 1'b1 || adc_channel !== 4'd3) begin
      errors++; $display("FAIL en_ch3_start: start=%b ch=%0d required 1 3", adc_conversion_start, adc_channel);
    end
    ns = n_start;
    repeat (3) step();
    enable = 1'b0;
    respond(5, 16'h0303);
    checks++;
    if (sample_valid !== 1'b1 || sample_channel !== 4'd3 || sample_data !== 16'h0303) begin
      errors++; $display("FAIL en_ch3_sample: vld=%b ch=%0d data=%h required 1 3 0303", sample_valid, sample_channel, sample_data);
    end
    step();
    checks++;
    if (scan_done !== 1'b0) begin errors++; $display("FAIL en_no_done: got %b required 0", scan_done); end
    repeat (40) step();
    checks++;
    if (n_start - ns !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL en_idle: starts=%0d busy=%b required 0 0", n_start - ns, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    channel_mask = 16'h0001; sample_period = 16'd5; enable = 1'b1;
    wait_start(20, ok);
    repeat (11) step();
    checks++;
    if (!ok || busy !== 1'b1 || overrun_count !== 16'd2) begin
      errors++; $display("FAIL rstmid_pre: ok=%b busy=%b overrun=%0d required 1 1 2", ok, busy, overrun_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid_clear: outputs=%h required 0", all_out); end
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid_after: outputs=%h required 0", all_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_drdy_timeout_race();
    test_fifo_full();
    test_overrun();
    test_enable_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
